// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Control unit for a multi-cycle RV32I datapath. The fetched instruction is
//   latched into an internal IR and stepped through
//   IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
//   Illegal encodings and memory timeouts park the unit in TRAP until reset.
//
// Optional build macro: CU_PERF_CNT_EN adds the retired_cnt/stall_cnt
//   performance counters. The default build leaves them out.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   instr            fetched instruction, sampled when imem_ack=1 in FETCH
//   imem_ack         instruction memory done
//   dmem_ack         data memory done
//   br_taken         branch comparator result for the IR's funct3
//   imem_req         instruction fetch request (FETCH only)
//   dmem_req/dmem_we data access request / write enable (MEM only)
//   dmem_size        IR funct3 while in MEM
//   reg_write        register file write enable (WB only)
//   pc_write, n_pc   PC update enable and next-PC select
//   alu_c, op_a,     ALU op, operand selects and immediate format,
//   op_b, imm_sel    driven in EXEC
//   wb_sel           write-back source, meaningful in WB
//   trap, trap_cause sticky trap flag and its cause
//   retired_cnt,     (CU_PERF_CNT_EN only) retired instructions and
//   stall_cnt        memory wait cycles
//   state_o          current state, for debug
//
// Handshake: a request (imem_req/dmem_req) stays high while its state is
//   held; the matching ack is taken only in a cycle where the request is
//   high, and the request drops in the cycle after the ack is sampled. An
//   ack with no request outstanding has no effect.
module multicycle_control_unit #(
   parameter int ALU_W       = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   input  logic             br_taken,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [2:0]       dmem_size,
   output logic             reg_write,
   output logic             pc_write,
   output logic [1:0]       n_pc,
   output logic [ALU_W-1:0] alu_c,
   output logic [1:0]       op_a,
   output logic             op_b,
   output logic [2:0]       imm_sel,
   output logic [1:0]       wb_sel,
   output logic             trap,
   output logic [1:0]       trap_cause,
`ifdef CU_PERF_CNT_EN
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] stall_cnt,
`endif
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SLT  = 4'd7;
   localparam logic [3:0] ALU_SLTU = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   // Wide enough to hold MEM_TIMEOUT itself.
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t            state, state_next;
   logic [31:0]       ir;
   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]        cause_q, cause_next;
   logic [3:0]        alu_op;
   logic              legal;
   logic              waiting;
   logic              timeout_hit;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];

   // Register/immediate fields are consumed by the datapath straight from
   // its own copy of the instruction, not by this unit.
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir[24:7];

   // A cycle with a request high and no ack.
   assign waiting = ((state == FETCH) && !imem_ack) || ((state == MEM) && !dmem_ack);

   // Fires on the MEM_TIMEOUT-th waiting cycle; an ack in that same cycle
   // takes priority because the ack branches are tested first below.
   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_BRANCH,
         OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal = 1'b1;
         OPC_OP: legal = (funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         default: legal = 1'b0;
      endcase
   end

   // funct7[5] picks SUB only for register-register ops (OP-IMM has no SUBI),
   // but picks SRA for both forms of the right shift.
   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         3'b000: alu_op = ((opcode == OPC_OP) && funct7[5]) ? ALU_SUB : ALU_ADD;
         3'b001: alu_op = ALU_SLL;
         3'b010: alu_op = ALU_SLT;
         3'b011: alu_op = ALU_SLTU;
         3'b100: alu_op = ALU_XOR;
         3'b101: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
         3'b110: alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ir       <= '0;
         wait_cnt <= '0;
         cause_q  <= '0;
      end else begin
         state <= state_next;
         if ((state == FETCH) && imem_ack) ir <= instr;
         if ((state_next == TRAP) && (state != TRAP)) cause_q <= cause_next;
         if (state_next != state) wait_cnt <= '0;
         else if (waiting)        wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      cause_next = 2'b00;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_size  = 3'b000;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      n_pc       = 2'b00;
      alu_c      = '0;
      op_a       = 2'b00;
      op_b       = 1'b0;
      imm_sel    = 3'b000;
      wb_sel     = 2'b00;
      trap       = 1'b0;
      trap_cause = cause_q;
      state_o    = state;
      case (state)
         IDLE: state_next = FETCH;
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               state_next = DECODE;
            end else if (timeout_hit) begin
               state_next = TRAP;
               cause_next = 2'b11;
            end
         end
         DECODE: begin
            if (legal) begin
               state_next = EXEC;
            end else begin
               state_next = TRAP;
               cause_next = 2'b01;
            end
         end
         EXEC: begin
            alu_c      = ALU_W'(ALU_ADD);
            state_next = WB;
            case (opcode)
               OPC_OP: alu_c = ALU_W'(alu_op);
               OPC_OPIMM: begin
                  alu_c = ALU_W'(alu_op);
                  op_b  = 1'b1;
               end
               OPC_LOAD: begin
                  op_b       = 1'b1;
                  state_next = MEM;
               end
               OPC_STORE: begin
                  op_b       = 1'b1;
                  imm_sel    = 3'b001;
                  state_next = MEM;
               end
               OPC_LUI: begin
                  op_a    = 2'b10;
                  op_b    = 1'b1;
                  imm_sel = 3'b010;
               end
               OPC_AUIPC: begin
                  op_a    = 2'b01;
                  op_b    = 1'b1;
                  imm_sel = 3'b010;
               end
               OPC_BRANCH: begin
                  imm_sel    = 3'b011;
                  pc_write   = br_taken;
                  n_pc       = 2'b10;
                  state_next = FETCH;
               end
               OPC_JAL: begin
                  op_a     = 2'b01;
                  op_b     = 1'b1;
                  imm_sel  = 3'b100;
                  pc_write = 1'b1;
                  n_pc     = 2'b01;
               end
               OPC_JALR: begin
                  op_b     = 1'b1;
                  pc_write = 1'b1;
                  n_pc     = 2'b11;
               end
               default: begin
                  // DECODE already filters these; kept safe regardless.
                  state_next = TRAP;
                  cause_next = 2'b01;
               end
            endcase
         end
         MEM: begin
            dmem_req  = 1'b1;
            dmem_we   = (opcode == OPC_STORE);
            dmem_size = funct3;
            if (dmem_ack) begin
               if (opcode == OPC_STORE) begin
                  pc_write   = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = WB;
               end
            end else if (timeout_hit) begin
               state_next = TRAP;
               cause_next = 2'b10;
            end
         end
         WB: begin
            reg_write  = 1'b1;
            state_next = FETCH;
            if (opcode == OPC_LOAD) begin
               wb_sel   = 2'b01;
               pc_write = 1'b1;
            end else if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
               // The jump target was written to the PC in EXEC.
               wb_sel = 2'b10;
            end else begin
               pc_write = 1'b1;
            end
         end
         TRAP: trap = 1'b1;
         default: state_next = IDLE;
      endcase
   end

`ifdef CU_PERF_CNT_EN
   // Neither counter can advance in TRAP: there is no exit to FETCH and no
   // waiting cycle from there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if ((state_next == FETCH) && ((state == EXEC) || (state == MEM) || (state == WB)))
            retired_cnt <= retired_cnt + 1'b1;
         if (waiting)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Each instruction is expanded by a
// transaction-level model into a list of per-cycle input vectors with the
// outputs that cycle must show; one runner drives each vector at the falling
// edge and compares the outputs 1 ns later.
module tb_multicycle_control_unit;
   localparam int ALU_W       = 4;
   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 32;

   localparam int K_ILL = 0, K_OP = 1, K_OPIMM = 2, K_LOAD = 3, K_STORE = 4;
   localparam int K_LUI = 5, K_AUIPC = 6, K_BRANCH = 7, K_JAL = 8, K_JALR = 9;

   // ALU code for each funct3 when funct7[5]=0: ADD SLL SLT SLTU XOR SRL OR AND
   localparam logic [3:0] ALU_F3 [8] = '{4'd0, 4'd5, 4'd7, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      instr;
   logic             imem_ack, dmem_ack, br_taken;
   logic             imem_req, dmem_req, dmem_we;
   logic [2:0]       dmem_size;
   logic             reg_write, pc_write;
   logic [1:0]       n_pc;
   logic [ALU_W-1:0] alu_c;
   logic [1:0]       op_a;
   logic             op_b;
   logic [2:0]       imm_sel;
   logic [1:0]       wb_sel;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [2:0]       state_o;
`ifdef CU_PERF_CNT_EN
   logic [CNT_W-1:0] retired_cnt, stall_cnt;
`endif

   multicycle_control_unit #(.ALU_W(ALU_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .br_taken(br_taken), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_size(dmem_size), .reg_write(reg_write), .pc_write(pc_write), .n_pc(n_pc),
      .alu_c(alu_c), .op_a(op_a), .op_b(op_b), .imm_sel(imm_sel), .wb_sel(wb_sel),
      .trap(trap), .trap_cause(trap_cause),
`ifdef CU_PERF_CNT_EN
      .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
      .state_o(state_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model ----------------
   typedef struct packed {
      logic [31:0] instr;
      logic        imem_ack, dmem_ack, br_taken;
      logic [2:0]  state;
      logic        imem_req, dmem_req, dmem_we;
      logic        chk_size;
      logic [2:0]  dmem_size;
      logic        reg_write, pc_write;
      logic        chk_npc;
      logic [1:0]  n_pc;
      logic        chk_wb;
      logic [1:0]  wb_sel;
      logic        trap;
      logic [1:0]  trap_cause;
      logic        chk_ops;
      logic [3:0]  alu_c;
      logic [1:0]  op_a;
      logic        op_b;
      logic [2:0]  imm_sel;
      logic [31:0] retired, stall;
   } cyc_t;
   localparam int EXP_W = $bits(cyc_t);

   logic [EXP_W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int m_retired = 0;
   int m_stall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int kind(input logic [31:0] ins);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      case (ins[6:0])
         7'h03: return K_LOAD;
         7'h23: return K_STORE;
         7'h13: return K_OPIMM;
         7'h63: return K_BRANCH;
         7'h6F: return K_JAL;
         7'h67: return K_JALR;
         7'h37: return K_LUI;
         7'h17: return K_AUIPC;
         7'h33: return ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)))) ? K_OP : K_ILL;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [3:0] op_alu(input logic [31:0] ins, input bit is_reg);
      logic [2:0] f3;
      f3 = ins[14:12];
      if (ins[30] && (f3 == 3'd5)) return 4'd9;
      if (ins[30] && (f3 == 3'd0) && is_reg) return 4'd1;
      return ALU_F3[f3];
   endfunction

   // Random inputs by default; callers pin the ones that matter that cycle.
   function automatic cyc_t blank();
      cyc_t c;
      c = '0;
      c.instr    = $urandom();
      c.imem_ack = 1'($urandom_range(0, 1));
      c.dmem_ack = 1'($urandom_range(0, 1));
      c.br_taken = 1'($urandom_range(0, 1));
      c.retired  = m_retired;
      c.stall    = m_stall;
      return c;
   endfunction

   task automatic push(input cyc_t c);
      exp_q.push_back(c);
   endtask

   task automatic gen_trap(input logic [1:0] cause, input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c = blank();
         c.state = 3'd7;
         c.trap = 1'b1;
         c.trap_cause = cause;
         push(c);
      end
   endtask

   task automatic gen_fetch(input logic [31:0] ins, input int delay, output bit ok);
      cyc_t c;
      ok = 1'b1;
      for (int i = 0; i < delay; i++) begin
         c = blank();
         c.state = 3'd1;
         c.imem_req = 1'b1;
         c.imem_ack = 1'b0;
         push(c);
         m_stall++;
         if (i + 1 == MEM_TIMEOUT) begin
            gen_trap(2'b11, 4);
            ok = 1'b0;
            return;
         end
      end
      c = blank();
      c.state = 3'd1;
      c.imem_req = 1'b1;
      c.imem_ack = 1'b1;
      c.instr = ins;
      push(c);
   endtask

   task automatic gen_mem(input logic [31:0] ins, input int delay, output bit ok);
      cyc_t c;
      bit store;
      store = (ins[6:0] == 7'h23);
      ok = 1'b1;
      for (int i = 0; i <= delay; i++) begin
         c = blank();
         c.state = 3'd4;
         c.dmem_req = 1'b1;
         c.dmem_we = store;
         c.chk_size = 1'b1;
         c.dmem_size = ins[14:12];
         c.dmem_ack = (i == delay);
         if (c.dmem_ack && store) begin
            c.pc_write = 1'b1;
            c.chk_npc = 1'b1;
            c.n_pc = 2'b00;
         end
         push(c);
         if (c.dmem_ack) begin
            if (store) m_retired++;
         end else begin
            m_stall++;
            if (i + 1 == MEM_TIMEOUT) begin
               gen_trap(2'b10, 4);
               ok = 1'b0;
               return;
            end
         end
      end
   endtask

   // Delays >= MEM_TIMEOUT mean the ack never comes.
   task automatic gen_instr(input logic [31:0] ins, input int f_delay, input int m_delay, input logic br);
      cyc_t c;
      bit ok;
      int k;
      gen_fetch(ins, f_delay, ok);
      if (!ok) return;
      k = kind(ins);
      c = blank();
      c.state = 3'd2;
      push(c);
      if (k == K_ILL) begin
         gen_trap(2'b01, 4);
         return;
      end
      c = blank();
      c.state = 3'd3;
      c.br_taken = br;
      case (k)
         K_OP:     begin c.chk_ops = 1; c.alu_c = op_alu(ins, 1'b1); end
         K_OPIMM:  begin c.chk_ops = 1; c.alu_c = op_alu(ins, 1'b0); c.op_b = 1; end
         K_LOAD:   begin c.chk_ops = 1; c.op_b = 1; end
         K_STORE:  begin c.chk_ops = 1; c.op_b = 1; c.imm_sel = 3'd1; end
         K_LUI:    begin c.chk_ops = 1; c.op_a = 2'd2; c.op_b = 1; c.imm_sel = 3'd2; end
         K_AUIPC:  begin c.chk_ops = 1; c.op_a = 2'd1; c.op_b = 1; c.imm_sel = 3'd2; end
         K_BRANCH: begin c.pc_write = br; c.chk_npc = 1; c.n_pc = 2'd2; end
         K_JAL:    begin c.pc_write = 1; c.chk_npc = 1; c.n_pc = 2'd1; end
         default:  begin c.pc_write = 1; c.chk_npc = 1; c.n_pc = 2'd3; end
      endcase
      push(c);
      if (k == K_BRANCH) begin
         m_retired++;
         return;
      end
      if ((k == K_LOAD) || (k == K_STORE)) begin
         gen_mem(ins, m_delay, ok);
         if (!ok || (k == K_STORE)) return;
      end
      c = blank();
      c.state = 3'd5;
      c.reg_write = 1'b1;
      c.chk_wb = 1'b1;
      c.wb_sel = (k == K_LOAD) ? 2'd1 : ((k == K_JAL) || (k == K_JALR)) ? 2'd2 : 2'd0;
      if ((k != K_JAL) && (k != K_JALR)) begin
         c.pc_write = 1'b1;
         c.chk_npc = 1'b1;
         c.n_pc = 2'd0;
      end
      push(c);
      m_retired++;
   endtask

   // ---------------- driver + compare ----------------
   task automatic run_n(input int n);
      cyc_t c;
      for (int i = 0; (i < n) && (exp_q.size() > 0); i++) begin
         c = cyc_t'(exp_q.pop_front());
         instr    = c.instr;
         imem_ack = c.imem_ack;
         dmem_ack = c.dmem_ack;
         br_taken = c.br_taken;
         #1;
         chk("state", 32'(state_o), 32'(c.state));
         chk("imem_req", 32'(imem_req), 32'(c.imem_req));
         chk("dmem_req", 32'(dmem_req), 32'(c.dmem_req));
         chk("dmem_we", 32'(dmem_we), 32'(c.dmem_we));
         chk("reg_write", 32'(reg_write), 32'(c.reg_write));
         chk("pc_write", 32'(pc_write), 32'(c.pc_write));
         chk("trap", 32'(trap), 32'(c.trap));
         chk("trap_cause", 32'(trap_cause), 32'(c.trap_cause));
         if (c.chk_npc) chk("n_pc", 32'(n_pc), 32'(c.n_pc));
         if (c.chk_wb) chk("wb_sel", 32'(wb_sel), 32'(c.wb_sel));
         if (c.chk_size) chk("dmem_size", 32'(dmem_size), 32'(c.dmem_size));
         if (c.chk_ops) begin
            chk("alu_c", 32'(alu_c), 32'(c.alu_c));
            chk("op_a", 32'(op_a), 32'(c.op_a));
            chk("op_b", 32'(op_b), 32'(c.op_b));
            chk("imm_sel", 32'(imm_sel), 32'(c.imm_sel));
         end
`ifdef CU_PERF_CNT_EN
         chk("retired_cnt", 32'(retired_cnt), c.retired);
         chk("stall_cnt", 32'(stall_cnt), c.stall);
`endif
         @(negedge clk);
      end
   endtask

   task automatic run_all();
      run_n(exp_q.size());
   endtask

   // ---------------- reset ----------------
   task automatic do_reset();
      cyc_t c;
      rst_n = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      br_taken = 1'b0;
      instr = '0;
      #1;
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_outputs", 32'({imem_req, dmem_req, dmem_we, dmem_size, reg_write, pc_write, n_pc,
                                alu_c, op_a, op_b, imm_sel, wb_sel, trap, trap_cause}), 32'd0);
`ifdef CU_PERF_CNT_EN
      chk("reset_counters", 32'(retired_cnt | stall_cnt), 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_retired = 0;
      m_stall = 0;
      c = blank();
      c.state = 3'd0;
      push(c);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int sz0;
      int cnt;
      int p;
      cyc_t c;
      rst_n = 1'b1;
      instr = '0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      br_taken = 1'b0;
      #1;

      // Legal program; ends with an unknown opcode.
      do_reset();
      gen_instr(32'h002081B3, 0, 0, 1'b0);            // add x3,x1,x2
      p = 0;
      foreach (exp_q[i]) begin
         c = cyc_t'(exp_q[i]);
         p = p * 8 + int'(c.state);
      end
      chk("pin_add_states", p, 'o1235);
      gen_instr(32'h402081B3, 0, 0, 1'b0);            // sub
      gen_instr(32'h4010D093, 0, 0, 1'b0);            // srai
      gen_instr(32'h0020C1B3, 0, 0, 1'b0);            // xor
      gen_instr(32'h0020B1B3, 0, 0, 1'b0);            // sltu
      gen_instr(32'h0020F1B3, 0, 0, 1'b0);            // and
      gen_instr(32'h4020D1B3, 0, 0, 1'b0);            // sra
      gen_instr(32'h00109093, 0, 0, 1'b0);            // slli
      gen_instr(32'h00500093, 2, 0, 1'b0);            // addi, slow fetch
      sz0 = exp_q.size();
      gen_instr(32'h0040A283, 0, 3, 1'b0);            // lw, dmem_ack after 3
      chk("pin_lw_cycles", exp_q.size() - sz0, 8);
      cnt = 0;
      for (int i = sz0; i < exp_q.size(); i++) begin
         c = cyc_t'(exp_q[i]);
         if (c.dmem_req) cnt++;
      end
      chk("pin_lw_dmem_req_cycles", cnt, 4);
      sz0 = exp_q.size();
      gen_instr(32'h0050A423, 0, 0, 1'b0);            // sw
      chk("pin_sw_cycles", exp_q.size() - sz0, 4);
      sz0 = exp_q.size();
      gen_instr(32'h00208463, 0, 0, 1'b1);            // beq taken
      chk("pin_beq_cycles", exp_q.size() - sz0, 3);
      gen_instr(32'h00208463, 0, 0, 1'b0);            // beq not taken
      gen_instr(32'h12345237, 0, 0, 1'b0);            // lui
      gen_instr(32'h00001217, 0, 0, 1'b0);            // auipc
      gen_instr(32'h010000EF, 0, 0, 1'b0);            // jal
      gen_instr(32'h00008067, 0, 0, 1'b0);            // jalr
      gen_instr(32'h0040A283, 0, MEM_TIMEOUT - 1, 1'b0); // ack on the limit cycle
      gen_instr(32'h0000007F, 0, 0, 1'b0);            // illegal opcode
      run_all();

      // Fetch resumes after reset; OP with funct7=0x01 traps.
      do_reset();
      gen_instr(32'h002081B3, 0, 0, 1'b0);
      gen_instr(32'h022081B3, 0, 0, 1'b0);
      run_all();

      // funct7=0x20 is only legal with funct3 000/101.
      do_reset();
      gen_instr(32'h402081B3, 0, 0, 1'b0);
      gen_instr(32'h402091B3, 0, 0, 1'b0);
      run_all();

      // Store whose dmem_ack never arrives.
      do_reset();
      gen_instr(32'h00500093, 0, 0, 1'b0);
      gen_instr(32'h0050A423, 0, MEM_TIMEOUT, 1'b0);
      chk("pin_stall_at_timeout", m_stall, 16);
      chk("pin_retired_at_timeout", m_retired, 1);
      run_all();

      // Fetch whose imem_ack never arrives.
      do_reset();
      gen_instr(32'h002081B3, MEM_TIMEOUT, 0, 1'b0);
      run_all();

      // Reset in the middle of a data access.
      do_reset();
      gen_instr(32'h0050A423, 0, 10, 1'b0);
      run_n(5);
      chk("pre_reset_state", 32'(state_o), 32'd4);
      chk("pre_reset_dmem_req", 32'(dmem_req), 32'd1);
      exp_q.delete();
      do_reset();
      exp_q.delete();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
